// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - steps an 8-entry mode/colour table or manual source, committing only on frame boundaries
module led_pattern_sequencer #(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int SIMULATION    = 0,
    parameter int DWELL_MS      = 4000,
    parameter int FRAME_TIMEOUT = 100_000
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       auto_en_in,
    input  logic       next_in,
    input  logic       prev_in,
    input  logic       manual_sel_in,
    input  logic [3:0] manual_mode_in,
    input  logic [2:0] manual_colour_in,
    input  logic [3:0] row_address_in,
    output logic [3:0] mode_out,
    output logic [2:0] colour_out,
    output logic [2:0] step_out,
    output logic       pending_out,
    output logic       change_out
);

    localparam int DWELL_CYCLES   = (SIMULATION != 0) ? 2000 : (SYS_CLK_FREQ / 1000) * DWELL_MS;
    localparam int TIMEOUT_CYCLES = (SIMULATION != 0) ? 500 : FRAME_TIMEOUT;
    localparam logic [31:0] DWELL_LAST   = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PENDING,
        S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  tgt_q, tgt_d;
    logic [31:0] dwell_q, dwell_d;
    logic [31:0] to_q, to_d;
    logic [3:0]  row_q;
    logic        manual_sel_q;
    logic [3:0]  manual_mode_q;
    logic [2:0]  manual_colour_q;

    logic       step_up, step_down, dwell_run, dwell_hit, boundary, manual_chg;
    logic [6:0] tgt_entry;
    logic [3:0] tgt_mode;
    logic [2:0] tgt_colour;

    function automatic logic [6:0] table_entry(input logic [2:0] idx);
        logic [6:0] e;
        case (idx)
            3'd0:    e = {4'd1, 3'd1};
            3'd1:    e = {4'd1, 3'd2};
            3'd2:    e = {4'd1, 3'd4};
            3'd3:    e = {4'd2, 3'd7};
            3'd4:    e = {4'd3, 3'd3};
            3'd5:    e = {4'd4, 3'd5};
            3'd6:    e = {4'd4, 3'd6};
            default: e = {4'd1, 3'd7};
        endcase
        return e;
    endfunction

    // Simultaneous next and prev cancel each other out.
    assign step_up    = next_in & ~prev_in;
    assign step_down  = prev_in & ~next_in;
    assign dwell_run  = auto_en_in & ~manual_sel_in;
    assign dwell_hit  = dwell_run && (dwell_q == DWELL_LAST);
    assign boundary   = (row_q == 4'd15) && (row_address_in == 4'd0);
    assign manual_chg = (manual_sel_in != manual_sel_q) ||
                        (manual_sel_in && ((manual_mode_in != manual_mode_q) ||
                                           (manual_colour_in != manual_colour_q)));

    assign tgt_entry  = table_entry(tgt_q);
    assign tgt_mode   = manual_sel_in ? manual_mode_in : tgt_entry[6:3];
    assign tgt_colour = manual_sel_in ? manual_colour_in : tgt_entry[2:0];

    assign pending_out = (state_q == S_PENDING);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        dwell_d = dwell_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                tgt_d   = 3'd0;
                dwell_d = '0;
                to_d    = '0;
                state_d = S_PENDING;
            end
            S_RUN: begin
                to_d = '0;
                // prev beats a coincident dwell expiry; next + expiry is a single +1
                if (step_down) begin
                    tgt_d   = step_out - 3'd1;
                    dwell_d = '0;
                    state_d = S_PENDING;
                end else if (step_up || dwell_hit) begin
                    tgt_d   = step_out + 3'd1;
                    dwell_d = '0;
                    state_d = S_PENDING;
                end else if (manual_chg) begin
                    tgt_d   = step_out;
                    state_d = S_PENDING;
                end else if (dwell_run) begin
                    dwell_d = dwell_q + 32'd1;
                end
            end
            S_PENDING: begin
                dwell_d = '0;
                to_d    = to_q + 32'd1;
                if (step_up) begin
                    tgt_d = tgt_q + 3'd1;
                end else if (step_down) begin
                    tgt_d = tgt_q - 3'd1;
                end
                if (boundary || (to_q == TIMEOUT_LAST)) begin
                    state_d = S_COMMIT;
                end
            end
            default: begin
                dwell_d = '0;
                to_d    = '0;
                state_d = S_RUN;
                if (step_up) begin
                    tgt_d   = tgt_q + 3'd1;
                    state_d = S_PENDING;
                end else if (step_down) begin
                    tgt_d   = tgt_q - 3'd1;
                    state_d = S_PENDING;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q         <= S_IDLE;
            tgt_q           <= '0;
            dwell_q         <= '0;
            to_q            <= '0;
            row_q           <= '0;
            manual_sel_q    <= 1'b0;
            manual_mode_q   <= '0;
            manual_colour_q <= '0;
            mode_out        <= '0;
            colour_out      <= '0;
            step_out        <= '0;
            change_out      <= 1'b0;
        end else begin
            state_q         <= state_d;
            tgt_q           <= tgt_d;
            dwell_q         <= dwell_d;
            to_q            <= to_d;
            row_q           <= row_address_in;
            manual_sel_q    <= manual_sel_in;
            manual_mode_q   <= manual_mode_in;
            manual_colour_q <= manual_colour_in;
            change_out      <= (state_q == S_COMMIT);
            if (state_q == S_COMMIT) begin
                mode_out   <= tgt_mode;
                colour_out <= tgt_colour;
                step_out   <= tgt_q;
            end
        end
    end

endmodule
